// File: rtl/ring_position_monitor.sv
// Tracks the token of a one-hot left/right ring counter: binary position, step direction,
// hold detection, lap counting and sticky one-hot / jump error flags.
module ring_position_monitor #(
  parameter  int WIDTH = 8,
  parameter  int LAP_W = 16,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clock0,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             err_clr,
  output logic [IDX_W-1:0] pos,
  output logic             pos_valid,
  output logic             dir,
  output logic             hold,
  output logic [LAP_W-1:0] lap_cnt,
  output logic             onehot_err,
  output logic             jump_err
);

  // state | meaning
  // IDLE  | no tracked position; next valid sample seeds pos
  // TRACK | following the token one step at a time
  // ERROR | bad word or jump seen; samples ignored until err_clr
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  localparam logic [IDX_W:0]   D_FWD   = (IDX_W+1)'(1);
  localparam logic [IDX_W:0]   D_BACK  = (IDX_W+1)'(WIDTH - 1);
  localparam logic [IDX_W:0]   D_RING  = (IDX_W+1)'(WIDTH);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] pos_q, pos_d;
  logic             pos_valid_q, pos_valid_d;
  logic             dir_q, dir_d;
  logic             hold_q, hold_d;
  logic [LAP_W-1:0] lap_cnt_q, lap_cnt_d;
  logic             onehot_err_q, onehot_err_d;
  logic             jump_err_q, jump_err_d;

  logic [IDX_W:0]   ones;
  logic [IDX_W-1:0] idx;
  logic             word_ok;
  logic [IDX_W:0]   diff;

  always_comb begin
    ones = '0;
    idx  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + {{IDX_W{1'b0}}, ring_in[i]};
      if (ring_in[i]) idx = IDX_W'(i);
    end
    word_ok = (ones == (IDX_W+1)'(1));
  end

  // Forward distance around the ring, always in 0..WIDTH-1 even for non power-of-two widths
  always_comb begin
    if (idx >= pos_q) diff = {1'b0, idx} - {1'b0, pos_q};
    else              diff = {1'b0, idx} + D_RING - {1'b0, pos_q};
  end

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    pos_valid_d  = pos_valid_q;
    dir_d        = dir_q;
    hold_d       = hold_q;
    lap_cnt_d    = lap_cnt_q;
    onehot_err_d = onehot_err_q;
    jump_err_d   = jump_err_q;

    if (err_clr) begin
      onehot_err_d = 1'b0;
      jump_err_d   = 1'b0;
      pos_valid_d  = 1'b0;
      hold_d       = 1'b0;
      state_d      = ST_IDLE;
    end else if (sample_en) begin
      case (state_q)
        ST_IDLE: begin
          if (word_ok) begin
            pos_d       = idx;
            pos_valid_d = 1'b1;
            hold_d      = 1'b0;
            state_d     = ST_TRACK;
          end else begin
            onehot_err_d = 1'b1;
            state_d      = ST_ERROR;
          end
        end
        ST_TRACK: begin
          if (!word_ok) begin
            onehot_err_d = 1'b1;
            pos_valid_d  = 1'b0;
            state_d      = ST_ERROR;
          end else if (diff == '0) begin
            hold_d = 1'b1;
          end else if (diff == D_FWD) begin
            dir_d  = 1'b1;
            hold_d = 1'b0;
            pos_d  = idx;
            if (pos_q == IDX_TOP && idx == '0) lap_cnt_d = lap_cnt_q + LAP_W'(1);
          end else if (diff == D_BACK) begin
            dir_d  = 1'b0;
            hold_d = 1'b0;
            pos_d  = idx;
            if (pos_q == '0 && idx == IDX_TOP) lap_cnt_d = lap_cnt_q + LAP_W'(1);
          end else begin
            jump_err_d  = 1'b1;
            pos_valid_d = 1'b0;
            state_d     = ST_ERROR;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock0 or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      pos_q        <= '0;
      pos_valid_q  <= 1'b0;
      dir_q        <= 1'b0;
      hold_q       <= 1'b0;
      lap_cnt_q    <= '0;
      onehot_err_q <= 1'b0;
      jump_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      pos_valid_q  <= pos_valid_d;
      dir_q        <= dir_d;
      hold_q       <= hold_d;
      lap_cnt_q    <= lap_cnt_d;
      onehot_err_q <= onehot_err_d;
      jump_err_q   <= jump_err_d;
    end
  end

  assign pos        = pos_q;
  assign pos_valid  = pos_valid_q;
  assign dir        = dir_q;
  assign hold       = hold_q;
  assign lap_cnt    = lap_cnt_q;
  assign onehot_err = onehot_err_q;
  assign jump_err   = jump_err_q;

endmodule

// File: tb/tb_ring_position_monitor.sv
// Bench for ring_position_monitor: directed scenarios plus random traffic against a
// position/lap reference model.
module tb_ring_position_monitor;

  localparam int W = 8;
  localparam int LW = 16;
  localparam int M_IDLE = 0, M_TRACK = 1, M_ERROR = 2;

  logic          clock0 = 1'b0;
  logic          reset = 1'b0;
  logic          sample_en = 1'b0;
  logic [W-1:0]  ring_in = '0;
  logic          err_clr = 1'b0;
  logic [2:0]    pos;
  logic          pos_valid, dir, hold, onehot_err, jump_err;
  logic [LW-1:0] lap_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  int m_st = M_IDLE, m_pos = 0, m_pv = 0, m_dir = 0, m_hold = 0, m_lap = 0, m_oh = 0, m_jp = 0;

  ring_position_monitor #(.WIDTH(W), .LAP_W(LW)) dut (
    .clock0(clock0), .reset(reset), .sample_en(sample_en), .ring_in(ring_in),
    .err_clr(err_clr), .pos(pos), .pos_valid(pos_valid), .dir(dir), .hold(hold),
    .lap_cnt(lap_cnt), .onehot_err(onehot_err), .jump_err(jump_err)
  );

  always #5 clock0 = ~clock0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pos"},        32'(pos),        32'(m_pos));
    chk({tag, ".pos_valid"},  32'(pos_valid),  32'(m_pv));
    chk({tag, ".dir"},        32'(dir),        32'(m_dir));
    chk({tag, ".hold"},       32'(hold),       32'(m_hold));
    chk({tag, ".lap_cnt"},    32'(lap_cnt),    32'(m_lap));
    chk({tag, ".onehot_err"}, 32'(onehot_err), 32'(m_oh));
    chk({tag, ".jump_err"},   32'(jump_err),   32'(m_jp));
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_pos = 0; m_pv = 0; m_dir = 0; m_hold = 0; m_lap = 0; m_oh = 0; m_jp = 0;
  endtask

  task automatic model_step(input bit en, input logic [W-1:0] word, input bit clr);
    int idx, d;
    bit ok;
    ok  = ($countones(word) == 1);
    idx = 0;
    for (int i = 0; i < W; i++) if (word[i]) idx = i;
    if (clr) begin
      m_oh = 0; m_jp = 0; m_pv = 0; m_hold = 0; m_st = M_IDLE;
    end else if (en) begin
      if (m_st == M_IDLE) begin
        if (ok) begin m_pos = idx; m_pv = 1; m_hold = 0; m_st = M_TRACK; end
        else    begin m_oh = 1; m_st = M_ERROR; end
      end else if (m_st == M_TRACK) begin
        if (!ok) begin
          m_oh = 1; m_pv = 0; m_st = M_ERROR;
        end else begin
          d = (idx - m_pos + W) % W;
          if (d == 0) m_hold = 1;
          else if (d == 1) begin
            if (m_pos == W - 1 && idx == 0) m_lap = (m_lap + 1) % (1 << LW);
            m_dir = 1; m_hold = 0; m_pos = idx;
          end else if (d == W - 1) begin
            if (m_pos == 0 && idx == W - 1) m_lap = (m_lap + 1) % (1 << LW);
            m_dir = 0; m_hold = 0; m_pos = idx;
          end else begin
            m_jp = 1; m_pv = 0; m_st = M_ERROR;
          end
        end
      end
    end
  endtask

  task automatic step(input string tag, input bit en, input logic [W-1:0] word, input bit clr);
    @(negedge clock0);
    sample_en = en;
    ring_in   = word;
    err_clr   = clr;
    @(posedge clock0);
    model_step(en, word, clr);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [W-1:0] word;
    int r, n;

    #12;
    model_reset();
    check_all("reset");
    @(negedge clock0);
    reset = 1'b1;

    step("t1.seed", 1, 8'h80, 0);
    for (int i = 0; i < 7; i++) begin
      word = 8'h01 << i;
      step("t1.left", 1, word, 0);
    end
    chk("t1.pos_end", 32'(pos), 32'd6);
    chk("t1.lap_end", 32'(lap_cnt), 32'd1);

    step("t2.a", 1, 8'h80, 0);
    step("t2.b", 1, 8'h01, 0);
    step("t2.wrap_right", 1, 8'h80, 0);
    chk("t2.right_dir", 32'(dir), 32'd0);
    step("t2.wrap_left", 1, 8'h01, 0);
    chk("t2.lap", 32'(lap_cnt), 32'd4);

    step("t3.hold", 1, 8'h01, 0);
    step("t3.jump", 1, 8'h04, 0);
    chk("t3.jump_err", 32'(jump_err), 32'd1);
    step("t3.ignored", 1, 8'h08, 0);
    step("t3.clr", 0, 8'h00, 1);

    step("t4.zero", 1, 8'h00, 0);
    chk("t4.onehot_err", 32'(onehot_err), 32'd1);
    step("t4.two_hot", 1, 8'h81, 0);
    step("t4.clr_drop", 1, 8'h10, 1);
    chk("t4.pv_after_clr", 32'(pos_valid), 32'd0);

    step("t5.seed", 1, 8'h10, 0);
    step("t5.hold", 1, 8'h10, 0);
    chk("t5.hold_flag", 32'(hold), 32'd1);
    step("t5.gated", 0, 8'hA5, 0);

    step("t6.walk", 1, 8'h08, 0);
    step("t6.walk", 1, 8'h04, 0);
    step("t6.walk", 1, 8'h02, 0);
    step("t6.walk", 1, 8'h01, 0);
    n = 0;
    while (m_lap != 16'hFFFF && n < 70000) begin
      word = (m_pos == 0) ? 8'h80 : 8'h01;
      step("t6.toggle", 1, word, 0);
      n++;
    end
    chk("t6.at_max", 32'(lap_cnt), 32'hFFFF);
    word = (m_pos == 0) ? 8'h80 : 8'h01;
    step("t6.wrap", 1, word, 0);
    chk("t6.wrapped", 32'(lap_cnt), 32'd0);

    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 99);
      if (r < 30)      step("rnd.left",  1, 8'h01 << ((m_pos + 1) % W), 0);
      else if (r < 60) step("rnd.right", 1, 8'h01 << ((m_pos + W - 1) % W), 0);
      else if (r < 68) step("rnd.hold",  1, 8'h01 << m_pos, 0);
      else if (r < 75) step("rnd.jump",  1, 8'h01 << $urandom_range(0, W - 1), 0);
      else if (r < 82) begin
        word = W'($urandom);
        if ($countones(word) == 1) word = 8'h00;
        step("rnd.bad", 1, word, 0);
      end
      else if (r < 91) step("rnd.gated", 0, W'($urandom), 0);
      else             step("rnd.clr", $urandom_range(0, 1), W'($urandom), 1);
    end

    @(posedge clock0);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clock0);
    reset = 1'b1;
    step("post_rst", 1, 8'h02, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
